pwm_duty_slew: RTL and testbench

//   Slew-rate limiter between the SPI register file and the PWM peripheral.

---
 rtl/pwm_slew_if.sv | 13 +
 rtl/pwm_duty_slew.sv | 93 +++++++++
 tb/tb_pwm_duty_slew.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pwm_slew_if.sv
// Duty-slew bundle between the register-file side (master) and the limiter (slave).
interface pwm_slew_if #(
  parameter int DUTY_W = 8
);
  logic [DUTY_W-1:0] target_duty;
  logic              bypass;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              done;

  modport master (output target_duty, bypass, input duty_out, busy, done);
  modport slave  (input target_duty, bypass, output duty_out, busy, done);
endinterface

// File: rtl/pwm_duty_slew.sv
// Slew-rate limiter: walks duty_out toward a registered target in STEP_SIZE steps
// every STEP_DIV clocks, with a bypass that loads the target directly.
module pwm_duty_slew #(
  parameter int DUTY_W    = 8,
  parameter int STEP_DIV  = 16,
  parameter int STEP_SIZE = 1
) (
  input  logic        clk,
  input  logic        rst,
  pwm_slew_if.slave   bus
);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(STEP_DIV - 1);
  localparam logic [DUTY_W:0] STEP_W    = (DUTY_W+1)'(STEP_SIZE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [DUTY_W-1:0] target_q;
  logic [DUTY_W-1:0] duty_q;
  logic [PW-1:0]     presc_q;
  logic [1:0]        state_q;
  logic              done_q;

  logic              tick;
  logic              tgt_gt;
  logic              tgt_lt;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] up_val;
  logic [DUTY_W-1:0] dn_val;
  logic [DUTY_W-1:0] duty_nxt;

  // Step math is one bit wider so a carry or borrow clamps to target
  // instead of wrapping.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    tgt_gt  = (target_q > duty_q);
    tgt_lt  = (target_q < duty_q);
    up_sum  = {1'b0, duty_q} + STEP_W;
    dn_diff = {1'b0, duty_q} - STEP_W;
    up_val  = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
    dn_val  = (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] < target_q)) ? target_q
                                                                    : dn_diff[DUTY_W-1:0];
    duty_nxt = duty_q;
    if (tick) duty_nxt = tgt_gt ? up_val : dn_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      duty_q   <= '0;
      presc_q  <= '0;
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
    end else begin
      target_q <= bus.target_duty;
      if (bus.bypass) begin
        duty_q  <= target_q;
        presc_q <= '0;
        state_q <= ST_IDLE;
        done_q  <= (duty_q != target_q);
      end else begin
        case (state_q)
          ST_IDLE: begin
            presc_q <= '0;
            done_q  <= 1'b0;
            if (tgt_gt)      state_q <= ST_UP;
            else if (tgt_lt) state_q <= ST_DOWN;
          end
          default: begin
            // Direction follows the live compare; presc keeps running so a
            // reversal does not restart the step cadence.
            presc_q <= tick ? '0 : presc_q + 1'b1;
            duty_q  <= duty_nxt;
            if (duty_nxt == target_q) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= (target_q > duty_nxt) ? ST_UP : ST_DOWN;
              done_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.duty_out = duty_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_pwm_duty_slew.sv
// Randomised + directed check of pwm_duty_slew (STEP_DIV 4 and 1, STEP_SIZE 16)
// against a per-cycle behavioural model.
module tb_pwm_duty_slew;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tgt = 8'h80;
  logic       byp = 1'b0;
  bit         chk_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pwm_slew_if #(.DUTY_W(8)) bus0 ();
  pwm_slew_if #(.DUTY_W(8)) bus1 ();
  assign bus0.target_duty = tgt;
  assign bus0.bypass      = byp;
  assign bus1.target_duty = tgt;
  assign bus1.bypass      = byp;

  pwm_duty_slew #(.DUTY_W(8), .STEP_DIV(4), .STEP_SIZE(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pwm_duty_slew #(.DUTY_W(8), .STEP_DIV(1), .STEP_SIZE(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Model: tq = registered target, cnt = clocks spent ramping since last step.
  int sdiv [2] = '{4, 1};
  int m_tq [2], m_duty [2], m_busy [2], m_done [2], m_cnt [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_tq[k] = 0; m_duty[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
      end else begin
        if (byp) begin
          m_done[k] = (m_duty[k] != m_tq[k]) ? 1 : 0;
          m_duty[k] = m_tq[k];
          m_busy[k] = 0;
        end else if (m_busy[k] == 0) begin
          m_done[k] = 0;
          m_busy[k] = (m_tq[k] != m_duty[k]) ? 1 : 0;
          m_cnt[k]  = 0;
        end else begin
          m_cnt[k]++;
          if (m_cnt[k] == sdiv[k]) begin
            m_cnt[k] = 0;
            if (m_tq[k] > m_duty[k]) m_duty[k] = (m_duty[k] + 16 > m_tq[k]) ? m_tq[k] : m_duty[k] + 16;
            else                     m_duty[k] = (m_duty[k] - 16 < m_tq[k]) ? m_tq[k] : m_duty[k] - 16;
          end
          if (m_duty[k] == m_tq[k]) begin m_busy[k] = 0; m_done[k] = 1; end
          else m_done[k] = 0;
        end
        m_tq[k] = int'(tgt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("duty0", bus0.duty_out, m_duty[0]);
      chk("busy0", bus0.busy,     m_busy[0]);
      chk("done0", bus0.done,     m_done[0]);
      chk("duty1", bus1.duty_out, m_duty[1]);
      chk("busy1", bus1.busy,     m_busy[1]);
      chk("done1", bus1.done,     m_done[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // reset held with a nonzero target
    cyc(2);
    chk_en = 1'b1;
    chk("rst_duty", bus0.duty_out, 8'h00);
    chk("rst_busy", bus0.busy, 1'b0);
    chk("rst_done", bus0.done, 1'b0);
    rst = 1'b0;
    cyc(2);
    chk("rel_busy", bus0.busy, 1'b1);

    // 0x00 -> 0x40 ramp
    rst = 1'b1; tgt = 8'h00; cyc(1); rst = 1'b0; cyc(1);
    tgt = 8'h40;
    cyc(2);  chk("t2_busy", bus0.busy, 1'b1); chk("t2_d0", bus0.duty_out, 8'h00);
    cyc(4);  chk("t2_d1", bus0.duty_out, 8'h10); chk("t2_model", m_duty[0], 32'h10);
             chk("div1_duty", bus1.duty_out, 8'h40); chk("div1_done", bus1.done, 1'b1);
    cyc(4);  chk("t2_d2", bus0.duty_out, 8'h20);
    cyc(4);  chk("t2_d3", bus0.duty_out, 8'h30);
    cyc(4);  chk("t2_d4", bus0.duty_out, 8'h40); chk("t2_done", bus0.done, 1'b1);
             chk("t2_idle", bus0.busy, 1'b0);
    cyc(1);  chk("t2_done_clr", bus0.done, 1'b0);

    // reversal mid-ramp at 0x20
    rst = 1'b1; cyc(1); rst = 1'b0; tgt = 8'h40;
    cyc(10); chk("t4_d20", bus0.duty_out, 8'h20);
    tgt = 8'h00;
    cyc(4);  chk("t4_d10", bus0.duty_out, 8'h10);
    cyc(4);  chk("t4_d00", bus0.duty_out, 8'h00); chk("t4_done", bus0.done, 1'b1);

    // clamp at the top and bottom of the range
    byp = 1'b1; tgt = 8'hF8; cyc(2); chk("t3_pre_hi", bus0.duty_out, 8'hF8);
    byp = 1'b0; cyc(1); tgt = 8'hFF;
    cyc(6);  chk("t3_hi", bus0.duty_out, 8'hFF); chk("t3_hi_done", bus0.done, 1'b1);
    byp = 1'b1; tgt = 8'h08; cyc(2); chk("t3_pre_lo", bus0.duty_out, 8'h08);
    byp = 1'b0; cyc(1); tgt = 8'h00;
    cyc(6);  chk("t3_lo", bus0.duty_out, 8'h00); chk("t3_lo_done", bus0.done, 1'b1);

    // bypass load
    cyc(1);
    byp = 1'b1; tgt = 8'hA5;
    cyc(1);  chk("t5_d_early", bus0.duty_out, 8'h00); chk("t5_busy0", bus0.busy, 1'b0);
    cyc(1);  chk("t5_d", bus0.duty_out, 8'hA5); chk("t5_done", bus0.done, 1'b1);
             chk("t5_busy1", bus0.busy, 1'b0);
    cyc(1);  chk("t5_done_clr", bus0.done, 1'b0);
    byp = 1'b0;

    // reset mid-ramp
    rst = 1'b1; cyc(1); rst = 1'b0; tgt = 8'h40;
    cyc(14); chk("t6_d30", bus0.duty_out, 8'h30);
    rst = 1'b1;
    cyc(1);  chk("t6_duty", bus0.duty_out, 8'h00); chk("t6_busy", bus0.busy, 1'b0);
             chk("t6_done", bus0.done, 1'b0);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      rst = (r < 4);
      if (r >= 900 && r < 960)      tgt = 8'($urandom);
      else if (r >= 960 && r < 975) tgt = 8'h00;
      else if (r >= 975 && r < 990) tgt = 8'hFF;
      if ($urandom_range(0, 99) < 2) byp = ~byp;
      if (byp && $urandom_range(0, 9) < 3) byp = 1'b0;
      cyc(1);
    end
    rst = 1'b0; byp = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
